// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the MMIO UART.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned OS_W       = 4;
    localparam int unsigned DIV_W      = 8;
    localparam int unsigned DATA_W     = 8;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_RXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_BAUD   = 2'd3;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a pop frees room for a same-cycle push.
module uart_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_pop;
    logic             do_push;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr[AW-1:0]];

    // Pointer update
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_mmio.sv
// MMIO UART: register decode, baud tick, 8N1 TX/RX engines around two FIFOs.
module uart_mmio
    import uart_pkg::*;
#(
    parameter int unsigned DIV_DEFAULT = 27,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address,
    input  logic [7:0]        w_data,
    input  logic              we,
    input  logic              re,
    output logic [7:0]        r_data,
    output logic              rx_empty,
    output logic              full,
    output logic              tx,
    input  logic              rx
);

    logic [1:0]       reg_sel;
    logic             unused_addr;
    logic [DIV_W-1:0] divisor, baud_cnt, baud_wdata;
    logic             tick, baud_we;
    logic             tx_push, tx_pop, tx_empty;
    logic [7:0]       tx_dout, rx_dout;
    logic             rx_push, rx_pop, rx_full;
    logic             ovr, ferr, ovr_set, ferr_set, status_clr, tx_busy;

    tx_state_t        tx_state, tx_state_n;
    logic [OS_W-1:0]  tx_cnt, tx_cnt_n;
    logic [2:0]       tx_bit, tx_bit_n;
    logic [7:0]       tx_shift, tx_shift_n;
    logic             tx_n;

    rx_state_t        rx_state, rx_state_n;
    logic [OS_W-1:0]  rx_cnt, rx_cnt_n;
    logic [2:0]       rx_bit, rx_bit_n;
    logic [7:0]       rx_shift, rx_shift_n;
    logic [1:0]       rx_sync;
    logic             rx_s;

    assign reg_sel     = address[3:2];
    assign unused_addr = &{1'b0, address[ADDR_W-1:4], address[1:0]};
    assign baud_we     = we && (reg_sel == REG_BAUD);
    assign baud_wdata  = (w_data == 8'd0) ? 8'd1 : w_data;
    assign tick        = (baud_cnt == '0);
    assign tx_push     = we && (reg_sel == REG_TXDATA) && !full;
    assign rx_pop      = re && (reg_sel == REG_RXDATA) && !rx_empty;
    assign status_clr  = re && (reg_sel == REG_STATUS);
    assign tx_busy     = (tx_state != TX_IDLE);
    assign rx_s        = rx_sync[1];

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push(tx_push), .pop(tx_pop), .din(w_data),
        .dout(tx_dout), .full(full), .empty(tx_empty)
    );

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push(rx_push), .pop(rx_pop), .din(rx_shift),
        .dout(rx_dout), .full(rx_full), .empty(rx_empty)
    );

    // Baud divisor and oversample tick counter; a BAUD write restarts the count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            divisor  <= DIV_W'(DIV_DEFAULT);
            baud_cnt <= DIV_W'(DIV_DEFAULT - 1);
        end else if (baud_we) begin
            divisor  <= baud_wdata;
            baud_cnt <= baud_wdata - 1'b1;
        end else if (tick) begin
            baud_cnt <= divisor - 1'b1;
        end else begin
            baud_cnt <= baud_cnt - 1'b1;
        end
    end

    // TX state register and registered serial output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx       <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            tx       <= tx_n;
        end
    end

    // TX next state; line level follows the state being entered
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_pop     = 1'b0;
        tx_n       = 1'b1;
        case (tx_state)
            TX_IDLE: if (tick && !tx_empty) begin
                tx_pop     = 1'b1;
                tx_shift_n = tx_dout;
                tx_cnt_n   = '0;
                tx_state_n = TX_START;
            end
            TX_START: if (tick) begin
                tx_cnt_n = tx_cnt + 1'b1;
                if (tx_cnt == OS_W'(OVERSAMPLE - 1)) begin
                    tx_bit_n   = '0;
                    tx_state_n = TX_DATA;
                end
            end
            TX_DATA: if (tick) begin
                tx_cnt_n = tx_cnt + 1'b1;
                if (tx_cnt == OS_W'(OVERSAMPLE - 1)) begin
                    tx_shift_n = {1'b0, tx_shift[7:1]};
                    tx_bit_n   = tx_bit + 1'b1;
                    if (tx_bit == 3'd7) tx_state_n = TX_STOP;
                end
            end
            TX_STOP: if (tick) begin
                tx_cnt_n = tx_cnt + 1'b1;
                if (tx_cnt == OS_W'(OVERSAMPLE - 1)) tx_state_n = TX_IDLE;
            end
            default: tx_state_n = TX_IDLE;
        endcase
        case (tx_state_n)
            TX_START: tx_n = 1'b0;
            TX_DATA:  tx_n = tx_shift_n[0];
            default:  tx_n = 1'b1;
        endcase
    end

    // RX synchronizer, state register and sticky error flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_sync  <= 2'b11;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            ovr      <= 1'b0;
            ferr     <= 1'b0;
        end else begin
            rx_sync  <= {rx_sync[0], rx};
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
            ovr      <= ovr_set  | (ovr  & ~status_clr);
            ferr     <= ferr_set | (ferr & ~status_clr);
        end
    end

    // RX next state: mid-bit sampling, stop-bit check and FIFO push
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_push    = 1'b0;
        ovr_set    = 1'b0;
        ferr_set   = 1'b0;
        case (rx_state)
            RX_IDLE: if (tick && !rx_s) begin
                rx_cnt_n   = '0;
                rx_state_n = RX_START;
            end
            RX_START: if (tick) begin
                rx_cnt_n = rx_cnt + 1'b1;
                if (rx_cnt == OS_W'(OVERSAMPLE / 2 - 1)) begin
                    rx_cnt_n   = '0;
                    rx_bit_n   = '0;
                    rx_state_n = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: if (tick) begin
                rx_cnt_n = rx_cnt + 1'b1;
                if (rx_cnt == OS_W'(OVERSAMPLE - 1)) begin
                    rx_shift_n = {rx_s, rx_shift[7:1]};
                    rx_bit_n   = rx_bit + 1'b1;
                    if (rx_bit == 3'd7) rx_state_n = RX_STOP;
                end
            end
            RX_STOP: if (tick) begin
                rx_cnt_n = rx_cnt + 1'b1;
                if (rx_cnt == OS_W'(OVERSAMPLE - 1)) begin
                    rx_state_n = RX_IDLE;
                    if (!rx_s)                  ferr_set = 1'b1;
                    else if (rx_full && !rx_pop) ovr_set  = 1'b1;
                    else                        rx_push  = 1'b1;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // Register read mux
    always_comb begin
        r_data = 8'h00;
        case (reg_sel)
            REG_RXDATA: r_data = rx_empty ? 8'h00 : rx_dout;
            REG_STATUS: r_data = {3'b000, ferr, ovr, tx_busy, full, rx_empty};
            REG_BAUD:   r_data = divisor;
            default:    r_data = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio: serial line decoded/encoded by bench tasks, queue model for RX FIFO.
module tb_uart_mmio;

    localparam int A_TX = 0;
    localparam int A_RX = 1;
    localparam int A_ST = 2;
    localparam int A_BD = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] address = '0;
    logic [7:0]  w_data = '0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [7:0]  r_data;
    logic        rx_empty, full, tx;
    logic        rx_drv = 1'b1;
    logic        loop = 1'b0;
    logic        rx_line;

    int n_cmp = 0;
    int n_bad = 0;
    int div_cur = 27;

    assign rx_line = loop ? tx : rx_drv;

    uart_mmio #(.DIV_DEFAULT(27), .FIFO_DEPTH(4), .ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .address(address), .w_data(w_data), .we(we), .re(re),
        .r_data(r_data), .rx_empty(rx_empty), .full(full), .tx(tx), .rx(rx_line)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic wr(input int a, input logic [7:0] d);
        @(negedge clk);
        address = 16'(a << 2);
        w_data  = d;
        we      = 1'b1;
        @(negedge clk);
        we      = 1'b0;
    endtask

    task automatic rd(input int a, input logic p, output logic [7:0] d);
        @(negedge clk);
        address = 16'(a << 2);
        re      = p;
        #1 d    = r_data;
        @(negedge clk);
        re      = 1'b0;
    endtask

    // Decode one 8N1 frame from tx by sampling bit centres of a recorded waveform
    task automatic capture(output logic [7:0] d, output int low_run, output logic ok);
        int bc;
        int t;
        logic s[$];
        bc = 16 * div_cur;
        ok = 1'b0;
        d = '0;
        low_run = 0;
        t = 0;
        while (tx !== 1'b1 && t < 20 * bc) begin @(negedge clk); t++; end
        t = 0;
        while (tx !== 1'b0 && t < 20 * bc) begin @(negedge clk); t++; end
        if (tx !== 1'b0) return;
        for (int i = 0; i < 10 * bc; i++) begin
            s.push_back(tx);
            @(negedge clk);
        end
        while (low_run < s.size() && s[low_run] == 1'b0) low_run++;
        for (int k = 0; k < 8; k++) d[k] = s[bc / 2 + bc * (k + 1)];
        ok = (s[bc / 2] == 1'b0) && (s[bc / 2 + 9 * bc] == 1'b1);
    endtask

    // Drive one frame onto rx; a zero stop bit is held for 3/4 of a bit
    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        int bc;
        bc = 16 * div_cur;
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (bc) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx_drv = b[k];
            repeat (bc) @(negedge clk);
        end
        rx_drv = stop_bit;
        repeat (stop_bit ? bc : (3 * bc) / 4) @(negedge clk);
        rx_drv = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        int lows;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b expected 1", tx); end
        n_cmp++; if (rx_empty !== 1'b1) begin n_bad++; $display("FAIL reset_rx_empty: got %b expected 1", rx_empty); end
        n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b expected 0", full); end
        rd(A_ST, 1'b0, d);
        n_cmp++; if (d !== 8'h01) begin n_bad++; $display("FAIL reset_status: got %h expected 01", d); end
        rd(A_BD, 1'b0, d);
        n_cmp++; if (d !== 8'd27) begin n_bad++; $display("FAIL reset_baud: got %h expected 1b", d); end
        rd(A_TX, 1'b0, d);
        n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL txdata_read: got %h expected 00", d); end
        rd(A_RX, 1'b0, d);
        n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL rxdata_empty_read: got %h expected 00", d); end
        // Abort a frame in flight
        wr(A_TX, 8'h00);
        repeat (800) @(negedge clk);
        n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL midframe_tx: got %b expected 0", tx); end
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL tx_after_reset_edge: got %b expected 1", tx); end
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++; if (rx_empty !== 1'b1 || full !== 1'b0) begin n_bad++; $display("FAIL midreset_flags: got rx_empty=%b full=%b expected 1 0", rx_empty, full); end
        rd(A_ST, 1'b0, d);
        n_cmp++; if (d !== 8'h01) begin n_bad++; $display("FAIL midreset_status: got %h expected 01", d); end
        rd(A_BD, 1'b0, d);
        n_cmp++; if (d !== 8'd27) begin n_bad++; $display("FAIL midreset_baud: got %h expected 1b", d); end
        lows = 0;
        repeat (600) begin @(negedge clk); if (tx !== 1'b1) lows++; end
        n_cmp++; if (lows !== 0) begin n_bad++; $display("FAIL midreset_line_idle: got %0d low cycles expected 0", lows); end
    endtask

    task automatic test_baud();
        logic [7:0] d, v;
        wr(A_BD, 8'h00);
        rd(A_BD, 1'b0, d);
        n_cmp++; if (d !== 8'h01) begin n_bad++; $display("FAIL baud_zero: got %h expected 01", d); end
        v = 8'($urandom_range(3, 255));
        wr(A_BD, v);
        rd(A_BD, 1'b0, d);
        n_cmp++; if (d !== v) begin n_bad++; $display("FAIL baud_rand: got %h expected %h", d, v); end
        wr(A_BD, 8'd2);
        div_cur = 2;
    endtask

    task automatic test_tx_frame();
        logic [7:0] bytes [3];
        logic [7:0] d, st;
        int lr;
        logic ok;
        bytes[0] = 8'hA5;
        bytes[1] = 8'($urandom);
        bytes[2] = 8'($urandom);
        for (int i = 0; i < 3; i++) begin
            wr(A_TX, bytes[i]);
            capture(d, lr, ok);
            n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL tx_framing[%0d]: got %b expected 1", i, ok); end
            n_cmp++; if (d !== bytes[i]) begin n_bad++; $display("FAIL tx_data[%0d]: got %h expected %h", i, d, bytes[i]); end
            if (i == 0) begin
                n_cmp++; if (lr !== 32) begin n_bad++; $display("FAIL tx_bit_time: got %0d expected 32", lr); end
            end
            repeat (4) @(negedge clk);
            rd(A_ST, 1'b0, st);
            n_cmp++; if (st !== 8'h01) begin n_bad++; $display("FAIL tx_idle_status[%0d]: got %h expected 01", i, st); end
        end
    endtask

    task automatic test_tx_full();
        logic [7:0] b [5];
        logic [7:0] d;
        int lr, t, falls;
        logic ok, prev;
        for (int i = 0; i < 5; i++) b[i] = 8'($urandom);
        wr(A_TX, 8'hFF);
        t = 0;
        while (tx !== 1'b0 && t < 200) begin @(negedge clk); t++; end
        n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL full_line_busy: got %b expected 0", tx); end
        for (int i = 0; i < 5; i++) begin
            wr(A_TX, b[i]);
            if (i == 2) begin
                n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL full_after_3: got %b expected 0", full); end
            end
            if (i >= 3) begin
                n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL full_after_%0d: got %b expected 1", i + 1, full); end
            end
        end
        for (int i = 0; i < 4; i++) begin
            capture(d, lr, ok);
            n_cmp++; if (ok !== 1'b1 || d !== b[i]) begin n_bad++; $display("FAIL full_stream[%0d]: got %h ok=%b expected %h ok=1", i, d, ok, b[i]); end
        end
        falls = 0;
        prev = tx;
        repeat (40 * div_cur * 16 / 2) begin
            @(negedge clk);
            if (prev === 1'b1 && tx === 1'b0) falls++;
            prev = tx;
        end
        n_cmp++; if (falls !== 0) begin n_bad++; $display("FAIL full_fifth_dropped: got %0d extra frames expected 0", falls); end
        n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL full_drained: got %b expected 0", full); end
    endtask

    task automatic test_rx_loopback();
        logic [7:0] b [3];
        logic [7:0] d;
        int t;
        loop = 1'b1;
        b[0] = 8'h3C;
        b[1] = 8'($urandom);
        b[2] = 8'($urandom);
        for (int i = 0; i < 3; i++) begin
            wr(A_TX, b[i]);
            t = 0;
            while (rx_empty !== 1'b0 && t < 40 * 16 * div_cur) begin @(negedge clk); t++; end
            n_cmp++; if (rx_empty !== 1'b0) begin n_bad++; $display("FAIL loop_arrived[%0d]: got rx_empty=%b expected 0", i, rx_empty); end
            rd(A_RX, 1'b0, d);
            n_cmp++; if (d !== b[i]) begin n_bad++; $display("FAIL loop_peek[%0d]: got %h expected %h", i, d, b[i]); end
            rd(A_RX, 1'b1, d);
            n_cmp++; if (d !== b[i]) begin n_bad++; $display("FAIL loop_pop[%0d]: got %h expected %h", i, d, b[i]); end
            n_cmp++; if (rx_empty !== 1'b1) begin n_bad++; $display("FAIL loop_empty[%0d]: got %b expected 1", i, rx_empty); end
            rd(A_RX, 1'b0, d);
            n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL loop_empty_read[%0d]: got %h expected 00", i, d); end
        end
        repeat (16 * div_cur) @(negedge clk);
    endtask

    task automatic test_rx_overrun();
        logic [7:0] b [5];
        logic [7:0] q [$];
        logic [7:0] d, exp_st;
        logic m_ovr;
        int t;
        loop = 1'b1;
        m_ovr = 1'b0;
        for (int i = 0; i < 5; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) wr(A_TX, b[i]);
        t = 0;
        while (full !== 1'b0 && t < 40 * 16 * div_cur) begin @(negedge clk); t++; end
        wr(A_TX, b[4]);
        for (int i = 0; i < 5; i++) begin
            if (q.size() < 4) q.push_back(b[i]);
            else m_ovr = 1'b1;
        end
        repeat (5 * 11 * 16 * div_cur + 200) @(negedge clk);
        exp_st = {3'b000, 1'b0, m_ovr, 1'b0, 1'b0, q.size() == 0};
        rd(A_ST, 1'b0, d);
        n_cmp++; if (d !== exp_st) begin n_bad++; $display("FAIL ovr_status: got %h expected %h", d, exp_st); end
        rd(A_ST, 1'b1, d);
        rd(A_ST, 1'b0, d);
        exp_st = {7'b0, q.size() == 0};
        n_cmp++; if (d !== exp_st) begin n_bad++; $display("FAIL ovr_cleared: got %h expected %h", d, exp_st); end
        while (q.size() > 0) begin
            rd(A_RX, 1'b1, d);
            n_cmp++; if (d !== q[0]) begin n_bad++; $display("FAIL ovr_data: got %h expected %h", d, q[0]); end
            void'(q.pop_front());
        end
        n_cmp++; if (rx_empty !== 1'b1) begin n_bad++; $display("FAIL ovr_drained: got %b expected 1", rx_empty); end
        loop = 1'b0;
    endtask

    task automatic test_ferr_glitch();
        logic [7:0] d, b;
        loop = 1'b0;
        rx_drv = 1'b1;
        repeat (16 * div_cur) @(negedge clk);
        send_rx(8'($urandom), 1'b0);
        repeat (4 * 16 * div_cur) @(negedge clk);
        rd(A_ST, 1'b0, d);
        n_cmp++; if (d !== 8'h11) begin n_bad++; $display("FAIL ferr_status: got %h expected 11", d); end
        rd(A_ST, 1'b1, d);
        rd(A_ST, 1'b0, d);
        n_cmp++; if (d !== 8'h01) begin n_bad++; $display("FAIL ferr_cleared: got %h expected 01", d); end
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (3 * div_cur) @(negedge clk);
        rx_drv = 1'b1;
        repeat (3 * 16 * div_cur) @(negedge clk);
        rd(A_ST, 1'b0, d);
        n_cmp++; if (d !== 8'h01) begin n_bad++; $display("FAIL glitch_status: got %h expected 01", d); end
        b = 8'($urandom);
        send_rx(b, 1'b1);
        repeat (16 * div_cur) @(negedge clk);
        n_cmp++; if (rx_empty !== 1'b0) begin n_bad++; $display("FAIL glitch_then_frame: got rx_empty=%b expected 0", rx_empty); end
        rd(A_RX, 1'b1, d);
        n_cmp++; if (d !== b) begin n_bad++; $display("FAIL glitch_frame_data: got %h expected %h", d, b); end
        rd(A_ST, 1'b0, d);
        n_cmp++; if (d !== 8'h01) begin n_bad++; $display("FAIL glitch_final_status: got %h expected 01", d); end
    endtask

    initial begin
        test_reset();
        test_baud();
        test_tx_frame();
        test_tx_full();
        test_rx_loopback();
        test_rx_overrun();
        test_ferr_glitch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
